// File: rtl/tinyalu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tinyalu_pkg                                                    |
// | Purpose  : Shared definitions for the tinyalu requester: opcode encoding,|
// |            requester FSM state codes and operand/result widths.          |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package tinyalu_pkg;

  localparam int c_operand_w = 8;
  localparam int c_result_w  = 16;

  // Opcodes 3'b101..3'b111 are not named here; the ALU treats any op with
  // bit 2 set as a multiply, and the requester forwards them unchanged.
  typedef enum logic [2:0] {
    NO_OP = 3'b000,
    ADD   = 3'b001,
    AND   = 3'b010,
    XOR   = 3'b011,
    MUL   = 3'b100
  } alu_op_e;

  // Requester FSM state encoding.
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_resp  = 2'd2;

endpackage : tinyalu_pkg
`default_nettype wire

// File: rtl/tinyalu_requester.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tinyalu_requester                                              |
// | Purpose  : Initiator side of the tinyalu start/done protocol. Accepts one |
// |            command at a time, drives it onto the ALU pins, holds start   |
// |            until done (or a timeout), and returns the captured result on |
// |            a valid/ready response stream.                                |
// | Ports    : clk, reset_n (sync, active-low)                                |
// |            cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op  - command stream      |
// |            rsp_valid/rsp_ready/rsp_result/rsp_op/rsp_timeout - response  |
// |            alu_a/alu_b/alu_op/alu_start/alu_done/alu_result - ALU pins   |
// |            ops_done (wrapping), timeouts (saturating) - statistics       |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tinyalu_requester
  import tinyalu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15  // legal range 5..255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_timeout,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic [15:0] ops_done,
  output logic [7:0]  timeouts
);

  // The wait counter starts at 0 on the first ISSUE cycle, so the last
  // allowed cycle is TIMEOUT_CYCLES-1; start is then high exactly
  // TIMEOUT_CYCLES cycles before an abort.
  localparam logic [7:0] c_wait_last = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]                r_state;
  logic [c_operand_w-1:0]    r_alu_a;
  logic [c_operand_w-1:0]    r_alu_b;
  logic [2:0]                r_alu_op;
  logic                      r_alu_start;
  logic [7:0]                r_wait_cnt;
  logic                      r_rsp_valid;
  logic [c_result_w-1:0]     r_rsp_result;
  logic                      r_rsp_timeout;
  logic [15:0]               r_ops_done;
  logic [7:0]                r_timeouts;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= c_st_idle;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_alu_start   <= 1'b0;
      r_wait_cnt    <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_timeout <= 1'b0;
      r_ops_done    <= '0;
      r_timeouts    <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (cmd_valid) begin
            r_alu_a    <= cmd_a;
            r_alu_b    <= cmd_b;
            r_alu_op   <= cmd_op;
            r_wait_cnt <= '0;
            if (cmd_op == NO_OP) begin
              // no_op never touches the ALU; answer immediately with zero.
              r_rsp_result  <= '0;
              r_rsp_timeout <= 1'b0;
              r_rsp_valid   <= 1'b1;
              r_state       <= c_st_resp;
            end else begin
              r_alu_start <= 1'b1;
              r_state     <= c_st_issue;
            end
          end
        end

        c_st_issue: begin
          // done is checked first so it wins over a simultaneous expiry.
          if (alu_done) begin
            r_rsp_result  <= alu_result;
            r_rsp_timeout <= 1'b0;
            r_alu_start   <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= c_st_resp;
          end else if (r_wait_cnt == c_wait_last) begin
            r_rsp_result  <= '0;
            r_rsp_timeout <= 1'b1;
            r_alu_start   <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= c_st_resp;
            if (r_timeouts != 8'hFF) begin
              r_timeouts <= r_timeouts + 8'd1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end

        c_st_resp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ops_done  <= r_ops_done + 16'd1;
            r_state     <= c_st_idle;
          end
        end

        default: begin
          r_state     <= c_st_idle;
          r_alu_start <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = (r_state == c_st_idle);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_op      = r_alu_op;
  assign rsp_timeout = r_rsp_timeout;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign alu_start   = r_alu_start;
  assign ops_done    = r_ops_done;
  assign timeouts    = r_timeouts;

endmodule : tinyalu_requester
`default_nettype wire

// File: tb/tb_tinyalu_requester.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tinyalu_requester                                           |
// | Purpose  : Self-checking bench for tinyalu_requester with a behavioural  |
// |            tinyalu model; expected responses are queued at issue time   |
// |            and compared by an independent response monitor.             |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_tinyalu_requester;

  localparam int TIMEOUT_CYCLES = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic [15:0] ops_done;
  logic [7:0]  timeouts;

  always #5 clk = ~clk;

  tinyalu_requester #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_timeout(rsp_timeout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .ops_done(ops_done), .timeouts(timeouts)
  );

  // ---------------- behavioural ALU ----------------
  // done is visible during the Nth cycle that start is high
  // (N=1 for add/and/xor, N=4 for mul, or lat_override when non-zero).
  logic alu_attached = 1'b1;
  logic done_force   = 1'b0;
  int   lat_override = 0;
  int   lat_cnt      = 0;
  int   lat_need;

  always @(posedge clk) begin
    if (!alu_start) lat_cnt <= 0;
    else            lat_cnt <= lat_cnt + 1;
  end

  always_comb begin
    lat_need = (lat_override != 0) ? lat_override : (alu_op[2] ? 4 : 1);
    alu_done = done_force | (alu_attached & alu_start & ((lat_cnt + 1) >= lat_need));
    alu_result = 16'h0000;
    case (alu_op)
      3'b001:  alu_result = {8'h00, alu_a} + {8'h00, alu_b};
      3'b010:  alu_result = {8'h00, alu_a & alu_b};
      3'b011:  alu_result = {8'h00, alu_a ^ alu_b};
      default: if (alu_op[2]) alu_result = 16'(alu_a) * 16'(alu_b);
    endcase
  end

  // ---------------- checking infrastructure ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] res;
    logic [2:0]  op;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   exp_ops = 0;

  // Response monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_result", 32'(rsp_result), 32'(e.res));
        chk("rsp_op", 32'(rsp_op), 32'(e.op));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
        exp_ops++;
      end
    end
  end

  // alu_start activity tracker.
  logic prev_start     = 1'b0;
  int   hi_run         = 0;
  int   low_run        = 1000;
  int   last_start_len = 0;
  int   rise_cnt       = 0;
  int   min_gap        = 1000;

  always @(negedge clk) begin
    if (alu_start) begin
      if (!prev_start) begin
        rise_cnt++;
        if (rise_cnt > 1 && low_run < min_gap) min_gap = low_run;
        hi_run = 0;
      end
      hi_run++;
    end else begin
      if (prev_start) begin
        last_start_len = hi_run;
        low_run = 0;
      end
      low_run++;
    end
    prev_start = alu_start;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [15:0] res, input logic to);
    int budget;
    exp_q.push_back('{res, op, to});
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    budget = 100;
    while (!cmd_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int rises_before;
    int budget;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_alu_start", 32'(alu_start), 32'd0);
    chk("reset_ops_done", 32'(ops_done), 32'd0);
    chk("reset_timeouts", 32'(timeouts), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // add FF+01
    send(8'hFF, 8'h01, 3'b001, 16'h0100, 1'b0);
    drain();
    chk("add_start_len", 32'(last_start_len), 32'd1);
    chk("add_ops_done", 32'(ops_done), 32'd1);

    // mul then xor, back to back
    send(8'h10, 8'h10, 3'b100, 16'h0100, 1'b0);
    send(8'hAA, 8'h0F, 3'b011, 16'h00A5, 1'b0);
    drain();
    chk("xor_start_len", 32'(last_start_len), 32'd1);
    chk("start_gap_min", 32'(min_gap >= 2), 32'd1);
    chk("mulxor_ops_done", 32'(ops_done), 32'(exp_ops));

    // mul latency alone
    send(8'h03, 8'h05, 3'b100, 16'h000F, 1'b0);
    drain();
    chk("mul_start_len", 32'(last_start_len), 32'd4);

    // no_op
    rises_before = rise_cnt;
    send(8'h12, 8'h34, 3'b000, 16'h0000, 1'b0);
    @(negedge clk);
    chk("noop_rsp_fast", 32'(rsp_valid), 32'd1);
    drain();
    chk("noop_no_start", 32'(rise_cnt), 32'(rises_before));

    // done outside ISSUE is ignored
    done_force = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_done_rsp_valid", 32'(rsp_valid), 32'd0);
    done_force = 1'b0;
    @(negedge clk);
    chk("stray_done_ops", 32'(ops_done), 32'(exp_ops));

    // backpressure on response
    rsp_ready = 1'b0;
    send(8'hF0, 8'h3C, 3'b010, 16'h0030, 1'b0);
    budget = 20;
    while (!rsp_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    exp_q.push_back('{16'h000B, 3'b001, 1'b0});
    cmd_a = 8'h05; cmd_b = 8'h06; cmd_op = 3'b001; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_result", 32'(rsp_result), 32'h0030);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_alu_op_held", 32'(alu_op), 32'd2);
    end
    rsp_ready = 1'b1;
    budget = 20;
    while (!cmd_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("bp_next_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    drain();
    chk("bp_ops_done", 32'(ops_done), 32'(exp_ops));

    // timeout with hung ALU
    alu_attached = 1'b0;
    send(8'h01, 8'h02, 3'b001, 16'h0000, 1'b1);
    drain();
    chk("to_start_len", 32'(last_start_len), 32'(TIMEOUT_CYCLES));
    chk("to_count", 32'(timeouts), 32'd1);

    // done arriving on the expiry cycle wins
    alu_attached = 1'b1;
    lat_override = TIMEOUT_CYCLES;
    send(8'h01, 8'h01, 3'b001, 16'h0002, 1'b0);
    drain();
    lat_override = 0;
    chk("donewins_start_len", 32'(last_start_len), 32'(TIMEOUT_CYCLES));
    chk("donewins_timeouts", 32'(timeouts), 32'd1);

    // timeout saturation: 255 more timeouts, 256 total
    alu_attached = 1'b0;
    for (int i = 0; i < 255; i++) begin
      send(8'h00, 8'h00, 3'b001, 16'h0000, 1'b1);
      if (i == 252) begin
        drain();
        chk("to_count_254", 32'(timeouts), 32'hFE);
      end
    end
    drain();
    chk("to_saturated", 32'(timeouts), 32'hFF);
    chk("to_ops_done", 32'(ops_done), 32'(exp_ops));
    alu_attached = 1'b1;

    // reset during ISSUE of a mul
    send(8'h07, 8'h09, 3'b100, 16'h003F, 1'b0);
    @(negedge clk);
    chk("mid_reset_in_issue", 32'(alu_start), 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q.delete();
    exp_ops = 0;
    @(negedge clk);
    chk("mid_reset_alu_start", 32'(alu_start), 32'd0);
    chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_reset_ops_done", 32'(ops_done), 32'd0);
    chk("mid_reset_timeouts", 32'(timeouts), 32'd0);
    chk("mid_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("mid_reset_no_rsp", 32'(rsp_valid), 32'd0);
    send(8'h01, 8'h02, 3'b001, 16'h0003, 1'b0);
    drain();
    chk("post_reset_ops_done", 32'(ops_done), 32'd1);
    chk("final_start_gap_min", 32'(min_gap >= 2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_tinyalu_requester
`default_nettype wire

// File: doc/tinyalu_requester.md
Name: tinyalu_requester

Overview:
- Initiator side of the tinyalu start/done command protocol.
- Accepts commands (A, B, op) on a valid/ready stream and drives them onto the ALU pins.
- Holds start until done, captures the result and returns it on a valid/ready response stream.
- Sits between a testbench/host command source and the tinyalu instance. Handles no_op and a hung ALU without deadlock.

Parameters:
- TIMEOUT_CYCLES, 15: maximum ISSUE cycles to wait for alu_done before aborting; legal range 5..255.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  requester can accept a command (high only in IDLE).
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_op  in  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul; 101-111 forwarded unchanged (the ALU treats op[2]=1 as mul).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_result  out  16  captured ALU result.
- rsp_op  out  3  opcode of the completed command.
- rsp_timeout  out  1  command aborted by timeout; rsp_result=0.
- alu_a  out  8  to ALU A.
- alu_b  out  8  to ALU B.
- alu_op  out  3  to ALU op.
- alu_start  out  1  to ALU start.
- alu_done  in  1  from ALU done.
- alu_result  in  16  from ALU result.
- ops_done  out  16  count of completed responses; wraps at 16'hFFFF.
- timeouts  out  8  count of timeouts; saturates at 8'hFF.

Behaviour:
- Reset values: synchronous; all outputs registered and zero during/after reset (state=IDLE, alu_start=0, rsp_valid=0, counters 0). Only cmd_ready, which is combinational from state, is 1 after reset.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch a/b/op into alu_a/alu_b/alu_op; these stay stable until the next accept.
  - op==000: go to RESP with rsp_result=0, rsp_timeout=0; alu_start is never asserted.
  - Otherwise go to ISSUE with alu_start=1 in the next cycle and wait counter cleared.
- ISSUE:
  - alu_start held 1; wait counter increments each cycle.
  - alu_done sampled high: capture alu_result into rsp_result, rsp_timeout=0, alu_start<=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES with no done: rsp_result=0, rsp_timeout=1, alu_start<=0, timeouts++ (saturating), go to RESP.
  - Done on the same cycle the counter expires: done wins.
- RESP:
  - rsp_valid=1; rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid<=0, ops_done++, go to IDLE.
- Start spacing:
  - alu_start is low for ≥2 cycles between commands (RESP + IDLE).
  - This is required so the ALU's registered done and mult done pipeline drain; the ALU re-fires done if start stays high.
- alu_done outside ISSUE is ignored.
- Expected ALU latency, start rising at edge N:
  - and/add/xor: done at edge N+1.
  - mul: done at edge N+4.
- Width rules:
  - rsp_result is a straight 16-bit capture; no arithmetic in this block.
  - rsp_op = latched op.
- Reset mid-operation: any state returns to IDLE next edge, alu_start drops, the pending response is discarded and not counted.
- Throughput: one command in flight, no queueing; cmd_ready low in ISSUE/RESP.

Decomposition:
- Shared package tinyalu_pkg:
  - op enum (NO_OP=3'b000, ADD=3'b001, AND=3'b010, XOR=3'b011, MUL=3'b100).
  - requester state enum.
  - operand/result width constants 8 and 16.
- Single module; no sub-module (the timeout counter and FSM are too small to split).

Test Plan:
- add A=8'hFF B=8'h01 with ALU attached -> alu_start high 1 cycle, rsp_result=16'h0100, rsp_op=001, rsp_timeout=0, ops_done=1.
- mul A=8'h10 B=8'h10 -> alu_done 4 cycles after start, rsp_result=16'h0100; then xor 8'hAA^8'h0F -> 16'h00A5, alu_start low ≥2 cycles between the two.
- no_op A=8'h12 B=8'h34 -> alu_start never high, rsp_result=0, rsp_timeout=0 within 2 cycles of accept.
- alu_done tied 0, op=001, TIMEOUT_CYCLES=15 -> alu_start high exactly 15 cycles, rsp_timeout=1, rsp_result=0, timeouts=1; 256 such commands -> timeouts=8'hFF.
- rsp_ready held low 5 cycles after an and of 8'hF0&8'h3C -> rsp_valid held, rsp_result=16'h0030 stable, cmd_ready=0 with cmd_valid=1; accepts next command only after the handshake.
- reset_n low for 1 cycle during ISSUE of a mul -> alu_start=0 and rsp_valid=0 next cycle, counters 0, no response emitted; next add 1+2 -> 16'h0003.
